// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit: FSM states, opcodes,
// ALU operation codes, bus source selects and CCR flag positions.
package cpu_pkg;

  // Each instruction class owns its own execute states so that every output
  // is a function of state alone, with no dependence on IR after decode.
  typedef enum logic [5:0] {
    S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
    S_LDA_IMM_4, S_LDA_IMM_5, S_LDA_IMM_6,
    S_LDB_IMM_4, S_LDB_IMM_5, S_LDB_IMM_6,
    S_LDA_DIR_4, S_LDA_DIR_5, S_LDA_DIR_6, S_LDA_DIR_7, S_LDA_DIR_8,
    S_LDB_DIR_4, S_LDB_DIR_5, S_LDB_DIR_6, S_LDB_DIR_7, S_LDB_DIR_8,
    S_STA_DIR_4, S_STA_DIR_5, S_STA_DIR_6, S_STA_DIR_7,
    S_STB_DIR_4, S_STB_DIR_5, S_STB_DIR_6, S_STB_DIR_7,
    S_ADD_AB_4, S_SUB_AB_4, S_AND_AB_4, S_OR_AB_4,
    S_BR_4, S_BR_5, S_BR_6, S_BR_NT_4,
    S_HALT
  } state_t;

  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD_AB  = 8'h42;
  localparam logic [7:0] OP_SUB_AB  = 8'h43;
  localparam logic [7:0] OP_AND_AB  = 8'h44;
  localparam logic [7:0] OP_OR_AB   = 8'h45;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BEQ     = 8'h23;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_INCA = 3'b100;
  localparam logic [2:0] ALU_DECA = 3'b101;

  localparam logic [1:0] BUS1_PC = 2'b00;
  localparam logic [1:0] BUS1_A  = 2'b01;
  localparam logic [1:0] BUS1_B  = 2'b10;

  localparam logic [1:0] BUS2_ALU  = 2'b00;
  localparam logic [1:0] BUS2_BUS1 = 2'b01;
  localparam logic [1:0] BUS2_MEM  = 2'b10;

  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

endpackage

// File: rtl/control_unit_if.sv
// Control/status bundle between the control unit and the datapath.
interface control_unit_if;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic       write;
  logic       halted;

  // Control unit side
  modport master (
    input  IR, CCR_Result,
    output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
           ALU_Sel, Bus1_Sel, Bus2_Sel, write, halted
  );

  // Datapath / memory side
  modport slave (
    output IR, CCR_Result,
    input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
           ALU_Sel, Bus1_Sel, Bus2_Sel, write, halted
  );
endinterface

// File: rtl/control_unit.sv
// Moore FSM sequencing the 8-bit CPU datapath through fetch, decode and
// execute. Outputs decode from state only; IR and flags steer next state.
module control_unit
  import cpu_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic           Clk,
  input  logic           Reset,
  control_unit_if.master cu
);

  state_t state_q, state_d;

  // V and C are carried on the bus but no branch here tests them.
  logic unused_flags;
  assign unused_flags = cu.CCR_Result[CCR_V] ^ cu.CCR_Result[CCR_C];

  // State register; reset returns to the top of fetch at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_FETCH_0;
    else       state_q <= state_d;
  end

  // Next-state sequencing; the opcode and flags only matter in DECODE_3.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH_0:  state_d = S_FETCH_1;
      S_FETCH_1:  state_d = S_FETCH_2;
      S_FETCH_2:  state_d = S_DECODE_3;
      S_DECODE_3: begin
        case (cu.IR)
          OP_LDA_IMM: state_d = S_LDA_IMM_4;
          OP_LDB_IMM: state_d = S_LDB_IMM_4;
          OP_LDA_DIR: state_d = S_LDA_DIR_4;
          OP_LDB_DIR: state_d = S_LDB_DIR_4;
          OP_STA_DIR: state_d = S_STA_DIR_4;
          OP_STB_DIR: state_d = S_STB_DIR_4;
          OP_ADD_AB:  state_d = S_ADD_AB_4;
          OP_SUB_AB:  state_d = S_SUB_AB_4;
          OP_AND_AB:  state_d = S_AND_AB_4;
          OP_OR_AB:   state_d = S_OR_AB_4;
          OP_BRA:     state_d = S_BR_4;
          OP_BMI:     state_d = cu.CCR_Result[CCR_N] ? S_BR_4 : S_BR_NT_4;
          OP_BEQ:     state_d = cu.CCR_Result[CCR_Z] ? S_BR_4 : S_BR_NT_4;
          default:    state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH_0;
        endcase
      end
      S_LDA_IMM_4: state_d = S_LDA_IMM_5;
      S_LDA_IMM_5: state_d = S_LDA_IMM_6;
      S_LDA_IMM_6: state_d = S_FETCH_0;
      S_LDB_IMM_4: state_d = S_LDB_IMM_5;
      S_LDB_IMM_5: state_d = S_LDB_IMM_6;
      S_LDB_IMM_6: state_d = S_FETCH_0;
      S_LDA_DIR_4: state_d = S_LDA_DIR_5;
      S_LDA_DIR_5: state_d = S_LDA_DIR_6;
      S_LDA_DIR_6: state_d = S_LDA_DIR_7;
      S_LDA_DIR_7: state_d = S_LDA_DIR_8;
      S_LDA_DIR_8: state_d = S_FETCH_0;
      S_LDB_DIR_4: state_d = S_LDB_DIR_5;
      S_LDB_DIR_5: state_d = S_LDB_DIR_6;
      S_LDB_DIR_6: state_d = S_LDB_DIR_7;
      S_LDB_DIR_7: state_d = S_LDB_DIR_8;
      S_LDB_DIR_8: state_d = S_FETCH_0;
      S_STA_DIR_4: state_d = S_STA_DIR_5;
      S_STA_DIR_5: state_d = S_STA_DIR_6;
      S_STA_DIR_6: state_d = S_STA_DIR_7;
      S_STA_DIR_7: state_d = S_FETCH_0;
      S_STB_DIR_4: state_d = S_STB_DIR_5;
      S_STB_DIR_5: state_d = S_STB_DIR_6;
      S_STB_DIR_6: state_d = S_STB_DIR_7;
      S_STB_DIR_7: state_d = S_FETCH_0;
      S_ADD_AB_4, S_SUB_AB_4, S_AND_AB_4, S_OR_AB_4: state_d = S_FETCH_0;
      S_BR_4:     state_d = S_BR_5;
      S_BR_5:     state_d = S_BR_6;
      S_BR_6:     state_d = S_FETCH_0;
      S_BR_NT_4:  state_d = S_FETCH_0;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH_0;
    endcase
  end

  // Output decode; everything is forced low while Reset is high so an
  // aborted store cannot leave a write strobe on the bus.
  always_comb begin
    cu.IR_Load  = 1'b0;
    cu.MAR_Load = 1'b0;
    cu.PC_Load  = 1'b0;
    cu.PC_Inc   = 1'b0;
    cu.A_Load   = 1'b0;
    cu.B_Load   = 1'b0;
    cu.CCR_Load = 1'b0;
    cu.ALU_Sel  = ALU_ADD;
    cu.Bus1_Sel = BUS1_PC;
    cu.Bus2_Sel = BUS2_ALU;
    cu.write    = 1'b0;
    cu.halted   = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        // PC -> MAR: start of fetch and of every operand fetch
        S_FETCH_0, S_LDA_IMM_4, S_LDB_IMM_4, S_LDA_DIR_4, S_LDB_DIR_4,
        S_STA_DIR_4, S_STB_DIR_4, S_BR_4: begin
          cu.Bus1_Sel = BUS1_PC;
          cu.Bus2_Sel = BUS2_BUS1;
          cu.MAR_Load = 1'b1;
        end
        // Step past the byte just addressed while memory reads it
        S_FETCH_1, S_LDA_IMM_5, S_LDB_IMM_5, S_LDA_DIR_5, S_LDB_DIR_5,
        S_STA_DIR_5, S_STB_DIR_5, S_BR_NT_4: cu.PC_Inc = 1'b1;
        S_FETCH_2: begin
          cu.Bus2_Sel = BUS2_MEM;
          cu.IR_Load  = 1'b1;
        end
        S_LDA_IMM_6, S_LDA_DIR_8: begin
          cu.Bus2_Sel = BUS2_MEM;
          cu.A_Load   = 1'b1;
        end
        S_LDB_IMM_6, S_LDB_DIR_8: begin
          cu.Bus2_Sel = BUS2_MEM;
          cu.B_Load   = 1'b1;
        end
        // Operand byte becomes the effective address
        S_LDA_DIR_6, S_LDB_DIR_6, S_STA_DIR_6, S_STB_DIR_6: begin
          cu.Bus2_Sel = BUS2_MEM;
          cu.MAR_Load = 1'b1;
        end
        S_STA_DIR_7: begin
          cu.Bus1_Sel = BUS1_A;
          cu.write    = 1'b1;
        end
        S_STB_DIR_7: begin
          cu.Bus1_Sel = BUS1_B;
          cu.write    = 1'b1;
        end
        S_ADD_AB_4, S_SUB_AB_4, S_AND_AB_4, S_OR_AB_4: begin
          cu.ALU_Sel  = (state_q == S_SUB_AB_4) ? ALU_SUB :
                        (state_q == S_AND_AB_4) ? ALU_AND :
                        (state_q == S_OR_AB_4)  ? ALU_OR  : ALU_ADD;
          cu.Bus2_Sel = BUS2_ALU;
          cu.A_Load   = 1'b1;
          cu.CCR_Load = 1'b1;
        end
        S_BR_6: begin
          cu.Bus2_Sel = BUS2_MEM;
          cu.PC_Load  = 1'b1;
        end
        S_HALT: cu.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by
// cycle and compares the full control word against hand-built vectors.
module tb_control_unit;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  control_unit_if cu_if ();

  control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .cu    (cu_if.master)
  );

  always #5 Clk = ~Clk;

  // Control word: {IR_Load,MAR_Load,PC_Load,PC_Inc,A_Load,B_Load,CCR_Load,
  //                ALU_Sel[2:0],Bus1_Sel[1:0],Bus2_Sel[1:0],write,halted}
  function automatic logic [15:0] v(input logic ir, mar, pcl, pci, al, bl, ccr,
                                    input logic [2:0] alu, input logic [1:0] b1, b2,
                                    input logic wr, h);
    return {ir, mar, pcl, pci, al, bl, ccr, alu, b1, b2, wr, h};
  endfunction

  function automatic logic [15:0] obs();
    return {cu_if.IR_Load, cu_if.MAR_Load, cu_if.PC_Load, cu_if.PC_Inc,
            cu_if.A_Load, cu_if.B_Load, cu_if.CCR_Load, cu_if.ALU_Sel,
            cu_if.Bus1_Sel, cu_if.Bus2_Sel, cu_if.write, cu_if.halted};
  endfunction

  logic [15:0] ZERO, F0, PCINC, F2, LDA_LD, LDB_LD, MAR_MEM, STA_W, STB_W;
  logic [15:0] DM_ADD, DM_SUB, BR6, HALTW;

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Check the current cycle, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic [15:0] e);
    chk(tag, obs(), e);
    @(negedge Clk);
  endtask

  task automatic fetch(input logic [7:0] op, input logic [3:0] flags);
    cu_if.IR = op;
    cu_if.CCR_Result = flags;
    cyc("fetch0", F0);
    cyc("fetch1", PCINC);
    cyc("fetch2", F2);
    cyc("decode3", ZERO);
  endtask

  initial begin
    ZERO    = '0;
    F0      = v(0,1,0,0,0,0,0, 3'b000, 2'b00, 2'b01, 0,0);
    PCINC   = v(0,0,0,1,0,0,0, 3'b000, 2'b00, 2'b00, 0,0);
    F2      = v(1,0,0,0,0,0,0, 3'b000, 2'b00, 2'b10, 0,0);
    LDA_LD  = v(0,0,0,0,1,0,0, 3'b000, 2'b00, 2'b10, 0,0);
    LDB_LD  = v(0,0,0,0,0,1,0, 3'b000, 2'b00, 2'b10, 0,0);
    MAR_MEM = v(0,1,0,0,0,0,0, 3'b000, 2'b00, 2'b10, 0,0);
    STA_W   = v(0,0,0,0,0,0,0, 3'b000, 2'b01, 2'b00, 1,0);
    STB_W   = v(0,0,0,0,0,0,0, 3'b000, 2'b10, 2'b00, 1,0);
    DM_ADD  = v(0,0,0,0,1,0,1, 3'b000, 2'b00, 2'b00, 0,0);
    DM_SUB  = v(0,0,0,0,1,0,1, 3'b001, 2'b00, 2'b00, 0,0);
    BR6     = v(0,0,1,0,0,0,0, 3'b000, 2'b00, 2'b10, 0,0);
    HALTW   = v(0,0,0,0,0,0,0, 3'b000, 2'b00, 2'b00, 0,1);

    cu_if.IR = 8'h00;
    cu_if.CCR_Result = 4'h0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("reset_outputs", obs(), ZERO);
    Reset = 1'b0;
    #1;

    // LDA_IMM: 7 cycles, A_Load in LS_6
    fetch(8'h86, 4'h0);
    cyc("lda_imm_4", F0);
    cyc("lda_imm_5", PCINC);
    cyc("lda_imm_6", LDA_LD);

    // LDB_DIR: 9 cycles with a wait in LS_7
    fetch(8'h89, 4'h0);
    cyc("ldb_dir_4", F0);
    cyc("ldb_dir_5", PCINC);
    cyc("ldb_dir_6", MAR_MEM);
    cyc("ldb_dir_7", ZERO);
    cyc("ldb_dir_8", LDB_LD);

    // STB_DIR: write only in LS_7 with Bus1=B
    fetch(8'h97, 4'h0);
    cyc("stb_dir_4", F0);
    cyc("stb_dir_5", PCINC);
    cyc("stb_dir_6", MAR_MEM);
    cyc("stb_dir_7", STB_W);

    // STA_DIR: Bus1=A
    fetch(8'h96, 4'h0);
    cyc("sta_dir_4", F0);
    cyc("sta_dir_5", PCINC);
    cyc("sta_dir_6", MAR_MEM);
    cyc("sta_dir_7", STA_W);

    fetch(8'h42, 4'h0);
    cyc("add_ab_4", DM_ADD);
    fetch(8'h43, 4'h0);
    cyc("sub_ab_4", DM_SUB);

    // BEQ taken (Z=1), then not taken (Z=0)
    fetch(8'h23, 4'b0100);
    cyc("beq_t_4", F0);
    cyc("beq_t_5", ZERO);
    cyc("beq_t_6", BR6);
    fetch(8'h23, 4'b0000);
    cyc("beq_nt_4", PCINC);

    // BMI taken on N, BMI not taken when only Z set, BRA always
    fetch(8'h21, 4'b1000);
    cyc("bmi_t_4", F0);
    cyc("bmi_t_5", ZERO);
    cyc("bmi_t_6", BR6);
    fetch(8'h21, 4'b0100);
    cyc("bmi_nt_4", PCINC);
    fetch(8'h20, 4'b0000);
    cyc("bra_4", F0);
    cyc("bra_5", ZERO);
    cyc("bra_6", BR6);

    // Reset rising mid-LS_7 of a store kills write immediately
    fetch(8'h97, 4'h0);
    cyc("stb2_4", F0);
    cyc("stb2_5", PCINC);
    cyc("stb2_6", MAR_MEM);
    chk("stb2_7", obs(), STB_W);
    #2 Reset = 1'b1;
    #1 chk("abort_write_low", obs(), ZERO);
    @(negedge Clk);
    chk("abort_held", obs(), ZERO);
    Reset = 1'b0;
    #1 chk("abort_fetch0", obs(), F0);

    // Illegal opcode parks in HALT
    fetch(8'hFF, 4'h0);
    for (int i = 0; i < 20; i++) cyc("halt_hold", HALTW);
    #1 Reset = 1'b1;
    #1 chk("halt_reset", obs(), ZERO);
    Reset = 1'b0;
    #1 chk("halt_exit_fetch0", obs(), F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
